tx_sched: RTL and testbench



---
 rtl/tx_sched.sv | 111 +++++++++++
 tb/tb_tx_sched.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_sched.sv
// Round-robin front end for the UART transmitter: arbitrates NREQ producers onto
// one tx write port and generates the clk_tx bit-rate square wave.
module tx_sched #(
  parameter  int WIDTH_DATA = 8,
  parameter  int NREQ       = 4,
  parameter  int DIV        = 16,
  localparam int GW         = $clog2(NREQ),
  localparam int CW         = $clog2(DIV)
) (
  input  logic                       i_clk,
  input  logic                       i_nrst,
  input  logic [NREQ-1:0]            i_req,
  input  logic [NREQ*WIDTH_DATA-1:0] i_data,
  output logic [NREQ-1:0]            o_ack,
  output logic [GW-1:0]              o_grant_id,
  output logic                       o_we,
  output logic [WIDTH_DATA-1:0]      o_data,
  input  logic                       i_mty,
  input  logic                       i_baud_en,
  output logic                       o_clk_tx
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t          state_r;
  logic            guard_r;
  logic [GW-1:0]   sel_s;
  logic            sel_valid_s;
  logic [CW-1:0]   cnt_r;
  logic [CW-1:0]   cnt_nxt_s;

  // Round-robin search starting just after the last granted requester
  always_comb begin
    int idx;
    sel_s       = o_grant_id;
    sel_valid_s = 1'b0;
    idx         = 0;
    // Walk the distance downward so the closest requester is written last and wins
    for (int i = NREQ; i >= 1; i--) begin
      idx = (int'(o_grant_id) + i) % NREQ;
      if (i_req[idx[GW-1:0]]) begin
        sel_valid_s = 1'b1;
        sel_s       = idx[GW-1:0];
      end else begin
        sel_valid_s = sel_valid_s;
      end
    end
  end

  // Grant FSM: one write per grant, then a fixed two-cycle guard for tx's o_mty latency
  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      state_r    <= ST_IDLE;
      guard_r    <= 1'b0;
      o_we       <= 1'b0;
      o_ack      <= '0;
      o_data     <= '0;
      o_grant_id <= GW'(NREQ - 1);
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (i_mty && sel_valid_s) begin
            o_we       <= 1'b1;
            o_ack      <= NREQ'(1) << sel_s;
            o_data     <= i_data[int'(sel_s)*WIDTH_DATA +: WIDTH_DATA];
            o_grant_id <= sel_s;
            guard_r    <= 1'b0;
            state_r    <= ST_HOLD;
          end else begin
            o_we  <= 1'b0;
            o_ack <= '0;
          end
        end
        ST_HOLD: begin
          o_we  <= 1'b0;
          o_ack <= '0;
          if (guard_r) begin
            state_r <= ST_IDLE;
          end else begin
            guard_r <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          o_we    <= 1'b0;
          o_ack   <= '0;
        end
      endcase
    end
  end

  assign cnt_nxt_s = (cnt_r == CW'(DIV - 1)) ? '0 : cnt_r + CW'(1);

  // Bit-rate generator: high while the next count is in the lower half of the period
  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      cnt_r    <= '0;
      o_clk_tx <= 1'b0;
    end else if (!i_baud_en) begin
      cnt_r    <= '0;
      o_clk_tx <= 1'b0;
    end else begin
      cnt_r    <= cnt_nxt_s;
      o_clk_tx <= (cnt_nxt_s < CW'(DIV / 2));
    end
  end

endmodule

// File: tb/tb_tx_sched.sv
// Self-checking bench for tx_sched: directed scenarios plus randomized traffic
// compared against a throughput/round-robin reference model.
module tb_tx_sched;
  localparam int W    = 8;
  localparam int NREQ = 4;
  localparam int DIV  = 16;
  localparam int GW   = 2;

  logic              clk = 1'b0;
  logic              nrst = 1'b0;
  logic              mty = 1'b0;
  logic              baud_en = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*W-1:0] data = '0;
  logic [NREQ-1:0]   o_ack;
  logic [GW-1:0]     o_grant_id;
  logic              o_we;
  logic [W-1:0]      o_data;
  logic              o_clk_tx;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int              m_gid, m_since, m_n;
  logic            m_we, m_clk;
  logic [NREQ-1:0] m_ack;
  logic [W-1:0]    m_data;

  tx_sched #(.WIDTH_DATA(W), .NREQ(NREQ), .DIV(DIV)) dut (
    .i_clk(clk), .i_nrst(nrst), .i_req(req), .i_data(data),
    .o_ack(o_ack), .o_grant_id(o_grant_id), .o_we(o_we), .o_data(o_data),
    .i_mty(mty), .i_baud_en(baud_en), .o_clk_tx(o_clk_tx)
  );

  always #5 clk = ~clk;

  function automatic int rr_pick(int last, logic [NREQ-1:0] r);
    for (int i = 1; i <= NREQ; i++)
      if (r[(last + i) % NREQ]) return (last + i) % NREQ;
    return -1;
  endfunction

  // Predict the outcome of the coming edge from the current inputs, then take the edge
  task automatic tick();
    int s;
    if (!nrst) begin
      m_gid = NREQ - 1; m_since = 3; m_we = 1'b0; m_ack = '0; m_data = '0; m_n = 0; m_clk = 1'b0;
    end else begin
      s = rr_pick(m_gid, req);
      if (mty && s >= 0 && m_since >= 3) begin
        m_we = 1'b1; m_ack = NREQ'(1) << s; m_data = data[s*W +: W]; m_gid = s; m_since = 1;
      end else begin
        m_we = 1'b0; m_ack = '0;
        if (m_since < 3) m_since++;
      end
      if (baud_en) begin
        m_n++; m_clk = ((m_n % DIV) < DIV / 2);
      end else begin
        m_n = 0; m_clk = 1'b0;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    nrst = 1'b0; req = '0; mty = 1'b1; baud_en = 1'b0;
    tick();
    nrst = 1'b1;
  endtask

  task automatic test_reset();
    nrst = 1'b0; req = 4'b1111; mty = 1'b1;
    for (int k = 0; k < NREQ; k++) data[k*W +: W] = 8'(8'h10 + k);
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if ({o_we, o_ack, o_clk_tx, o_grant_id} !== {1'b0, 4'b0000, 1'b0, 2'd3}) begin
        n_fail++;
        $display("FAIL reset_state: got we=%b ack=%b clk_tx=%b gid=%0d, want 0 0000 0 3", o_we, o_ack, o_clk_tx, o_grant_id);
      end
    end
    nrst = 1'b1;
    tick();
    n_checks++;
    if ({o_we, o_ack, o_data, o_grant_id} !== {1'b1, 4'b0001, 8'h10, 2'd0}) begin
      n_fail++;
      $display("FAIL reset_first_grant: got we=%b ack=%b data=%h gid=%0d, want 1 0001 10 0", o_we, o_ack, o_data, o_grant_id);
    end
    req = 4'b0000;
  endtask

  task automatic test_single_write();
    int gap;
    do_reset();
    data[2*W +: W] = 8'hA5; req = 4'b0100;
    tick();
    n_checks++;
    if ({o_we, o_ack, o_data} !== {1'b1, 4'b0100, 8'hA5}) begin
      n_fail++;
      $display("FAIL single_write: got we=%b ack=%b data=%h, want 1 0100 a5", o_we, o_ack, o_data);
    end
    data[2*W +: W] = 8'h5A;
    gap = 0;
    for (int c = 1; c <= 6 && gap == 0; c++) begin
      tick();
      n_checks++;
      if ({o_we, o_ack, o_data, o_grant_id} !== {m_we, m_ack, m_data, GW'(m_gid)}) begin
        n_fail++;
        $display("FAIL single_follow: got we=%b ack=%b data=%h, want %b %b %h", o_we, o_ack, o_data, m_we, m_ack, m_data);
      end
      if (o_we) gap = c;
    end
    n_checks++;
    if (gap != 3) begin
      n_fail++;
      $display("FAIL single_gap: next write after %0d cycles, want 3", gap);
    end
    req = '0;
  endtask

  task automatic test_round_robin();
    int got[$];
    int exp_order[5] = '{0, 1, 2, 3, 0};
    do_reset();
    req = 4'b1111;
    for (int c = 0; c < 40 && got.size() < 5; c++) begin
      tick();
      if (o_we) begin
        got.push_back(int'(o_grant_id));
        n_checks++;
        if (!$onehot(o_ack) || o_ack[o_grant_id] !== 1'b1) begin
          n_fail++;
          $display("FAIL rr_onehot: got ack=%b gid=%0d, want single bit at gid", o_ack, o_grant_id);
        end
      end
    end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (i >= got.size()) begin
        n_fail++;
        $display("FAIL rr_order: grant %0d missing, want %0d", i, exp_order[i]);
      end else if (got[i] != exp_order[i]) begin
        n_fail++;
        $display("FAIL rr_order: grant %0d went to %0d, want %0d", i, got[i], exp_order[i]);
      end
    end
    req = '0;
  endtask

  task automatic test_back_pressure();
    int bad;
    do_reset();
    mty = 1'b0; req = 4'b0001; data[0 +: W] = 8'h3C;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (o_we !== 1'b0 || o_ack !== 4'b0000) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL bp_hold: %0d cycles with a write while tx full, want 0", bad);
    end
    mty = 1'b1;
    tick();
    n_checks++;
    if ({o_we, o_ack, o_data} !== {1'b1, 4'b0001, 8'h3C}) begin
      n_fail++;
      $display("FAIL bp_release: got we=%b ack=%b data=%h, want 1 0001 3c", o_we, o_ack, o_data);
    end
    req = '0;
  endtask

  task automatic test_mid_reset();
    int rep;
    do_reset();
    data[1*W +: W] = 8'h11; data[2*W +: W] = 8'h22; req = 4'b0110;
    tick();
    n_checks++;
    if ({o_we, o_ack, o_grant_id} !== {1'b1, 4'b0010, 2'd1}) begin
      n_fail++;
      $display("FAIL midrst_grant: got we=%b ack=%b gid=%0d, want 1 0010 1", o_we, o_ack, o_grant_id);
    end
    req = 4'b0100;
    nrst = 1'b0;
    tick();
    n_checks++;
    if ({o_we, o_ack, o_grant_id, o_data} !== {1'b0, 4'b0000, 2'd3, 8'h00}) begin
      n_fail++;
      $display("FAIL midrst_state: got we=%b ack=%b gid=%0d data=%h, want 0 0000 3 00", o_we, o_ack, o_grant_id, o_data);
    end
    nrst = 1'b1;
    tick();
    n_checks++;
    if ({o_we, o_ack, o_grant_id, o_data} !== {1'b1, 4'b0100, 2'd2, 8'h22}) begin
      n_fail++;
      $display("FAIL midrst_regrant: got we=%b ack=%b gid=%0d data=%h, want 1 0100 2 22", o_we, o_ack, o_grant_id, o_data);
    end
    req = '0;
    rep = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (o_ack[1]) rep++;
    end
    n_checks++;
    if (rep != 0) begin
      n_fail++;
      $display("FAIL midrst_no_repeat: ack[1] repeated %0d times, want 0", rep);
    end
  endtask

  task automatic test_baud();
    int rise_a, rise_b, highs, bad;
    logic prev;
    do_reset();
    baud_en = 1'b1;
    prev = 1'b0; rise_a = -1; rise_b = -1; highs = 0; bad = 0;
    for (int c = 1; c <= 48; c++) begin
      tick();
      if (o_clk_tx !== m_clk) bad++;
      if (o_clk_tx && !prev) begin rise_a = rise_b; rise_b = c; end
      if (c > 16 && c <= 32 && o_clk_tx) highs++;
      prev = o_clk_tx;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL baud_wave: %0d cycles off the reference waveform, want 0", bad);
    end
    n_checks++;
    if (rise_b - rise_a != DIV) begin
      n_fail++;
      $display("FAIL baud_period: got %0d cycles, want %0d", rise_b - rise_a, DIV);
    end
    n_checks++;
    if (highs != DIV / 2) begin
      n_fail++;
      $display("FAIL baud_duty: high %0d of %0d cycles, want %0d", highs, DIV, DIV / 2);
    end
    for (int c = 0; c < DIV && (m_n % DIV) != 5; c++) tick();
    baud_en = 1'b0;
    tick();
    n_checks++;
    if (o_clk_tx !== 1'b0) begin
      n_fail++;
      $display("FAIL baud_disable: got clk_tx=%b, want 0", o_clk_tx);
    end
    baud_en = 1'b1;
    bad = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (o_clk_tx !== ((c + 1) < DIV / 2 ? 1'b1 : 1'b0)) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL baud_restart: %0d cycles off the cnt=0 phase, want 0", bad);
    end
    baud_en = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      mty = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 29) == 0) baud_en = ~baud_en;
      nrst = ($urandom_range(0, 149) != 0);
      for (int k = 0; k < NREQ; k++) begin
        if (!req[k] && $urandom_range(0, 3) == 0) begin
          data[k*W +: W] = 8'($urandom);
          req[k] = 1'b1;
        end
      end
      tick();
      n_checks++;
      if ({o_we, o_ack, o_data, o_grant_id, o_clk_tx} !== {m_we, m_ack, m_data, GW'(m_gid), m_clk}) begin
        n_fail++;
        $display("FAIL random_c%0d: got we=%b ack=%b data=%h gid=%0d clk=%b, want %b %b %h %0d %b",
                 c, o_we, o_ack, o_data, o_grant_id, o_clk_tx, m_we, m_ack, m_data, m_gid, m_clk);
      end
      req = req & ~m_ack;
    end
    nrst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_back_pressure();
    test_mid_reset();
    test_baud();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
